// File: rtl/bit_serial_adder_pkg.sv
// bit_serial_adder_pkg: shared FSM state encoding, default width and bit-counter sizing
package bit_serial_adder_pkg;
  localparam int WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// fa_cell: single-bit full adder (a, b, cin -> sum, cout)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder, ports clk/rst, in_valid/in_ready + op_a/op_b/op_cin in, out_valid/out_ready + sum/cout out, busy while shifting
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_n;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_n;
  logic             c_q;
  logic             c_n;
  logic             cout_q;
  logic             cout_n;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_n;
  logic             bit_s;
  logic             bit_c;
  logic             accept;
  logic             shifting;
  logic             last;
  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .sum  (bit_s),
    .cout (bit_c)
  );
  assign accept   = state == IDLE && in_valid;
  assign shifting = state == SHIFT;
  assign last     = shifting && cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) :
              state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
    a_n     = accept ? op_a : shifting ? a_q >> 1 : a_q;
    b_n     = accept ? op_b : shifting ? b_q >> 1 : b_q;
    c_n     = accept ? op_cin : shifting ? bit_c : c_q;
    cnt_n   = accept ? '0 : shifting ? cnt_q + 1'b1 : cnt_q;
    res_n   = shifting ? {bit_s, res_q[WIDTH-1:1]} : res_q;
    // published only on the final bit so sum/cout always show the last finished result
    sum_n   = last ? res_n : sum_q;
    cout_n  = last ? bit_c : cout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state  <= state_n;
      a_q    <= a_n;
      b_q    <= b_n;
      c_q    <= c_n;
      cnt_q  <= cnt_n;
      res_q  <= res_n;
      sum_q  <= sum_n;
      cout_q <= cout_n;
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = shifting;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: random and directed checks of bit_serial_adder against a timing-level arithmetic model
module tb_bit_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         op_cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         cout;
  logic         busy;
  logic [W-1:0] sum;
  int           errors = 0;
  int           checks = 0;
  longint       cyc = 0;
  longint       acc = 0;
  bit           pend = 1'b0;
  bit           started = 1'b0;
  logic [W:0]   exp_r = '0;
  logic [W:0]   last = '0;
  int           n_done = 0;
  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: one op in flight, result due W edges after the accept edge, held until taken
  always @(posedge clk) begin
    bit ov;
    ov = pend && cyc >= acc + W;
    cyc <= cyc + 1;
    if (rst) begin
      started <= 1'b1;
      pend    <= 1'b0;
      last    <= '0;
    end else if (!pend && in_valid) begin
      pend  <= 1'b1;
      acc   <= cyc + 1;
      exp_r <= (W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(op_cin);
    end else if (ov && out_ready) begin
      pend   <= 1'b0;
      last   <= exp_r;
      n_done <= n_done + 1;
    end
  end
  always @(negedge clk) begin
    bit ov;
    ov = pend && cyc >= acc + W;
    if (started) begin
      chk("in_ready", 64'(in_ready), 64'(!pend));
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("busy", 64'(busy), 64'(pend && !ov));
      chk("sum", 64'(sum), 64'(ov ? exp_r[W-1:0] : last[W-1:0]));
      chk("cout", 64'(cout), 64'(ov ? exp_r[W] : last[W]));
    end
  end
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] es, input logic ec,
                        input bit garble, input int hold);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      if (garble) begin
        in_valid = ~in_valid; op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({name, " latency"}, 64'(n), 64'(W + 1));
    chk({name, " sum"}, 64'(sum), 64'(es));
    chk({name, " cout"}, 64'(cout), 64'(ec));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold valid"}, 64'(out_valid), 64'(1));
      chk({name, " hold sum"}, 64'({cout, sum}), 64'({ec, es}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " release ready"}, 64'(in_ready), 64'(1));
    chk({name, " release valid"}, 64'(out_valid), 64'(0));
  endtask
  initial begin
    int start;
    int budget;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'(1));
    chk("reset sum", 64'({cout, sum}), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    chk("early out_ready", 64'(out_valid), 64'(0));
    run_op("5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 0);
    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 5);
    run_op("garble", 8'h21, 8'h13, 1'b1, 8'h35, 1'b0, 1'b1, 1);
    @(negedge clk);
    op_a = 8'hC3; op_b = 8'h71; op_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 64'(in_ready), 64'(1));
    chk("abort out_valid", 64'(out_valid), 64'(0));
    chk("abort sum", 64'({cout, sum}), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("abort never shown", 64'(out_valid), 64'(0));
    end
    start = n_done;
    budget = 0;
    while (n_done - start < 1000 && budget < 40000) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 3) != 0;
      op_a = W'($urandom);
      op_b = W'($urandom);
      op_cin = 1'($urandom);
      out_ready = 1'($urandom);
      budget++;
    end
    in_valid = 1'b0;
    chk("random op count", 64'(n_done - start), 64'(1000));
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
